// File: rtl/atm_pkg.sv
// atm_pkg
// Shared definitions for the multi-account ATM controller: controller state
// encoding and the menu codes presented on i_transactionMenu.
package atm_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LANG   = 3'd1,
    S_PIN    = 3'd2,
    S_MENU   = 3'd3,
    S_AMOUNT = 3'd4,
    S_EXEC   = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  localparam logic [2:0] TXN_DEP  = 3'b001;
  localparam logic [2:0] TXN_WITH = 3'b010;
  localparam logic [2:0] TXN_XFER = 3'b100;
  localparam logic [2:0] TXN_BAL  = 3'b011;

endpackage

// File: rtl/atm_acct_bank.sv
// atm_acct_bank
// Per-account storage: balances, wrong-PIN try counters and lock flags.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rd_src_i / rd_dst_i      account addresses (source, transfer destination)
//   src_bal_o / dst_bal_o    balances of the addressed accounts
//   src_tries_o, src_lock_o  try count and lock flag of the source account
//   passwd_i, pin_ok_o       PIN compare for the source account
//   we_src_i/wd_src_i        source balance write
//   we_dst_i/wd_dst_i        destination balance write (same cycle as source)
//   try_inc_i/try_clr_i      source try counter update
//   lock_set_i               lock the source account
module atm_acct_bank import atm_pkg::*; #(
  parameter int          NUM_ACCTS   = 4,
  parameter int          ACCT_W      = 2,
  parameter int          BAL_W       = 16,
  parameter int unsigned INIT_BAL    = 1000,
  parameter logic [3:0]  DEFAULT_PIN = 4'hA,
  parameter int          TRY_W       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ACCT_W-1:0] rd_src_i,
  input  logic [ACCT_W-1:0] rd_dst_i,
  output logic [BAL_W-1:0]  src_bal_o,
  output logic [BAL_W-1:0]  dst_bal_o,
  output logic [TRY_W-1:0]  src_tries_o,
  output logic              src_lock_o,
  input  logic [3:0]        passwd_i,
  output logic              pin_ok_o,
  input  logic              we_src_i,
  input  logic [BAL_W-1:0]  wd_src_i,
  input  logic              we_dst_i,
  input  logic [BAL_W-1:0]  wd_dst_i,
  input  logic              try_inc_i,
  input  logic              try_clr_i,
  input  logic              lock_set_i
);

  logic [BAL_W-1:0]     bal_q   [NUM_ACCTS];
  logic [TRY_W-1:0]     tries_q [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] lock_q;

  // Address compare per entry keeps out-of-range indices harmless (read 0, no write).
  always_comb begin
    src_bal_o   = '0;
    dst_bal_o   = '0;
    src_tries_o = '0;
    src_lock_o  = 1'b0;
    for (int i = 0; i < NUM_ACCTS; i++) begin
      if (ACCT_W'(i) == rd_src_i) begin
        src_bal_o   = bal_q[i];
        src_tries_o = tries_q[i];
        src_lock_o  = lock_q[i];
      end
      if (ACCT_W'(i) == rd_dst_i) dst_bal_o = bal_q[i];
    end
  end

  // PINs are not reprogrammable, so every account compares against the reset PIN.
  assign pin_ok_o = (passwd_i == DEFAULT_PIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal_q[i]   <= BAL_W'(INIT_BAL);
        tries_q[i] <= '0;
      end
      lock_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ACCTS; i++) begin
        if (ACCT_W'(i) == rd_src_i) begin
          if (we_src_i) bal_q[i] <= wd_src_i;
          if (try_clr_i)      tries_q[i] <= '0;
          else if (try_inc_i) tries_q[i] <= tries_q[i] + 1'b1;
          if (lock_set_i) lock_q[i] <= 1'b1;
        end
        if (we_dst_i && (ACCT_W'(i) == rd_dst_i)) bal_q[i] <= wd_dst_i;
      end
    end
  end

endmodule

// File: rtl/atm_ctrl_multi.sv
// atm_ctrl_multi
// Multi-account ATM transaction controller: card/language/PIN session flow,
// deposit, withdraw, transfer and balance enquiry with lockout and timeout.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   i_card_in, i_acct                 card present level, account on insertion
//   i_lang, i_passwd, i_pin_valid     language strobe, PIN and its strobe
//   i_transactionMenu, i_txn_valid    menu code and its strobe
//   i_amount, i_dst_acct, i_conf      amount, transfer destination, confirm strobe
//   i_cancel                          abort strobe
//   o_pin, o_depConf, o_withConf, o_transferConf, o_balEnq,
//   o_balNotEnough, o_err             one-cycle result pulses
//   o_balance                         source balance after the last EXEC
//   o_locked, o_busy                  levels: account locked, session active
//
// state    | meaning
// IDLE     | no session; waits for card rising edge
// LANG     | waiting for language select
// PIN      | waiting for PIN entry
// MENU     | waiting for a menu code
// AMOUNT   | waiting for amount confirm
// EXEC     | one cycle: bank updated, result decoded
// DONE     | result pulse visible; returns to MENU
module atm_ctrl_multi import atm_pkg::*; #(
  parameter int          NUM_ACCTS   = 4,
  parameter int          ACCT_W      = 2,
  parameter int          BAL_W       = 16,
  parameter int unsigned INIT_BAL    = 1000,
  parameter logic [3:0]  DEFAULT_PIN = 4'hA,
  parameter int          MAX_TRIES   = 3,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_card_in,
  input  logic [ACCT_W-1:0] i_acct,
  input  logic              i_lang,
  input  logic [3:0]        i_passwd,
  input  logic              i_pin_valid,
  input  logic [2:0]        i_transactionMenu,
  input  logic              i_txn_valid,
  input  logic [BAL_W-1:0]  i_amount,
  input  logic [ACCT_W-1:0] i_dst_acct,
  input  logic              i_conf,
  input  logic              i_cancel,
  output logic              o_pin,
  output logic              o_depConf,
  output logic              o_withConf,
  output logic              o_transferConf,
  output logic              o_balEnq,
  output logic [BAL_W-1:0]  o_balance,
  output logic              o_balNotEnough,
  output logic              o_err,
  output logic              o_locked,
  output logic              o_busy
);

  localparam int              TRY_W      = $clog2(MAX_TRIES + 1);
  localparam int              TMR_W      = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIMEOUT_CYC - 1);

  state_e             state_q;
  logic               card_q;
  logic [ACCT_W-1:0]  acct_q, dst_q, rd_src;
  logic [2:0]         txn_q;
  logic [BAL_W-1:0]   amt_q;
  logic [TMR_W-1:0]   tmr_q;

  logic [BAL_W-1:0]   src_bal, dst_bal, wd_src, wd_dst, exec_bal;
  logic [TRY_W-1:0]   src_tries;
  logic               src_lock, pin_ok, we_src, we_dst;
  logic [BAL_W:0]     sum_src, sum_dst;
  logic               dst_ok, r_dep, r_with, r_xfer, r_bal, r_nen, r_err;
  logic               strobe_any, tmr_reload, timeout;
  logic               pin_ev, last_try, try_inc, try_clr, lock_set;

  // Lock check on insertion needs the incoming account before it is latched.
  assign rd_src = (state_q == S_IDLE) ? i_acct : acct_q;

  atm_acct_bank #(
    .NUM_ACCTS(NUM_ACCTS), .ACCT_W(ACCT_W), .BAL_W(BAL_W),
    .INIT_BAL(INIT_BAL), .DEFAULT_PIN(DEFAULT_PIN), .TRY_W(TRY_W)
  ) u_bank (
    .clk(clk), .rst(rst),
    .rd_src_i(rd_src), .rd_dst_i(dst_q),
    .src_bal_o(src_bal), .dst_bal_o(dst_bal),
    .src_tries_o(src_tries), .src_lock_o(src_lock),
    .passwd_i(i_passwd), .pin_ok_o(pin_ok),
    .we_src_i(we_src), .wd_src_i(wd_src),
    .we_dst_i(we_dst), .wd_dst_i(wd_dst),
    .try_inc_i(try_inc), .try_clr_i(try_clr), .lock_set_i(lock_set)
  );

  assign sum_src = {1'b0, src_bal} + {1'b0, amt_q};
  assign sum_dst = {1'b0, dst_bal} + {1'b0, amt_q};
  assign dst_ok  = (32'(dst_q) < NUM_ACCTS) && (dst_q != acct_q);

  // EXEC commits unconditionally, so an abort in that cycle cannot tear a transfer.
  always_comb begin
    we_src = 1'b0;  wd_src = src_bal;
    we_dst = 1'b0;  wd_dst = dst_bal;
    r_dep  = 1'b0;  r_with = 1'b0;  r_xfer = 1'b0;
    r_bal  = 1'b0;  r_nen  = 1'b0;  r_err  = 1'b0;
    if (state_q == S_EXEC) begin
      case (txn_q)
        TXN_DEP: begin
          if (sum_src[BAL_W]) r_err = 1'b1;
          else begin we_src = 1'b1; wd_src = sum_src[BAL_W-1:0]; r_dep = 1'b1; end
        end
        TXN_WITH: begin
          if (amt_q > src_bal) r_nen = 1'b1;
          else begin we_src = 1'b1; wd_src = src_bal - amt_q; r_with = 1'b1; end
        end
        TXN_XFER: begin
          if (!dst_ok)              r_err = 1'b1;
          else if (amt_q > src_bal) r_nen = 1'b1;
          else if (sum_dst[BAL_W])  r_err = 1'b1;
          else begin
            we_src = 1'b1; wd_src = src_bal - amt_q;
            we_dst = 1'b1; wd_dst = sum_dst[BAL_W-1:0];
            r_xfer = 1'b1;
          end
        end
        default: r_bal = 1'b1;
      endcase
    end
  end

  assign exec_bal = we_src ? wd_src : src_bal;

  // Every state change out of a wait state is caused by a strobe or an abort,
  // so reloading on strobes and in the transient states covers state changes.
  assign strobe_any = i_lang | i_pin_valid | i_txn_valid | i_conf | i_cancel;
  assign tmr_reload = (state_q == S_IDLE) || (state_q == S_EXEC) ||
                      (state_q == S_DONE) || strobe_any;
  assign timeout    = !tmr_reload && (tmr_q == '0);

  assign pin_ev   = (state_q == S_PIN) && i_card_in && !i_cancel && i_pin_valid;
  assign last_try = (32'(src_tries) + 1 == MAX_TRIES);
  assign try_clr  = pin_ev && pin_ok;
  assign try_inc  = pin_ev && !pin_ok;
  assign lock_set = try_inc && last_try;

  assign o_busy = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      card_q         <= 1'b0;
      acct_q         <= '0;
      dst_q          <= '0;
      txn_q          <= '0;
      amt_q          <= '0;
      tmr_q          <= TMR_RELOAD;
      o_pin          <= 1'b0;
      o_depConf      <= 1'b0;
      o_withConf     <= 1'b0;
      o_transferConf <= 1'b0;
      o_balEnq       <= 1'b0;
      o_balance      <= '0;
      o_balNotEnough <= 1'b0;
      o_err          <= 1'b0;
      o_locked       <= 1'b0;
    end else begin
      card_q         <= i_card_in;
      tmr_q          <= tmr_reload ? TMR_RELOAD : tmr_q - 1'b1;
      o_pin          <= 1'b0;
      o_depConf      <= r_dep;
      o_withConf     <= r_with;
      o_transferConf <= r_xfer;
      o_balEnq       <= r_bal;
      o_balNotEnough <= r_nen;
      o_err          <= r_err;
      if (state_q == S_EXEC) o_balance <= exec_bal;
      if (!i_card_in) o_locked <= 1'b0;

      if (state_q == S_IDLE) begin
        if (i_card_in && !card_q) begin
          acct_q <= i_acct;
          if (src_lock) begin
            o_err    <= 1'b1;
            o_locked <= 1'b1;
          end else begin
            state_q <= S_LANG;
          end
        end
      end else if (!i_card_in || i_cancel) begin
        state_q <= S_IDLE;
      end else if (timeout) begin
        state_q <= S_IDLE;
        o_err   <= 1'b1;
      end else begin
        case (state_q)
          S_LANG: if (i_lang) state_q <= S_PIN;
          S_PIN: begin
            if (i_pin_valid) begin
              if (pin_ok) begin
                o_pin   <= 1'b1;
                state_q <= S_MENU;
              end else if (last_try) begin
                o_err    <= 1'b1;
                o_locked <= 1'b1;
                state_q  <= S_IDLE;
              end
            end
          end
          S_MENU: begin
            if (i_txn_valid) begin
              case (i_transactionMenu)
                TXN_DEP, TXN_WITH, TXN_XFER: begin
                  txn_q   <= i_transactionMenu;
                  state_q <= S_AMOUNT;
                end
                TXN_BAL: begin
                  txn_q   <= i_transactionMenu;
                  state_q <= S_EXEC;
                end
                default: o_err <= 1'b1;
              endcase
            end
          end
          S_AMOUNT: begin
            if (i_conf) begin
              amt_q   <= i_amount;
              dst_q   <= i_dst_acct;
              state_q <= S_EXEC;
            end
          end
          S_EXEC:  state_q <= S_DONE;
          S_DONE:  state_q <= S_MENU;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_ctrl_multi.sv
module tb_atm_ctrl_multi;

  localparam int T_CYC   = 1024;
  localparam int BAL_MAX = 65535;
  localparam logic [2:0] C_DEP  = 3'b001;
  localparam logic [2:0] C_WITH = 3'b010;
  localparam logic [2:0] C_XFER = 3'b100;
  localparam logic [2:0] C_BAL  = 3'b011;
  // expected result vectors {dep, with, xfer, balEnq, notEnough, err}
  localparam logic [5:0] R_DEP  = 6'b100000;
  localparam logic [5:0] R_WITH = 6'b010000;
  localparam logic [5:0] R_XFER = 6'b001000;
  localparam logic [5:0] R_BAL  = 6'b000100;
  localparam logic [5:0] R_NEN  = 6'b000010;
  localparam logic [5:0] R_ERR  = 6'b000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_card_in, i_lang, i_pin_valid, i_txn_valid, i_conf, i_cancel;
  logic [1:0]  i_acct, i_dst_acct;
  logic [3:0]  i_passwd;
  logic [2:0]  i_transactionMenu;
  logic [15:0] i_amount;
  logic        o_pin, o_depConf, o_withConf, o_transferConf, o_balEnq;
  logic        o_balNotEnough, o_err, o_locked, o_busy;
  logic [15:0] o_balance;

  always #5 clk = ~clk;

  atm_ctrl_multi dut (
    .clk(clk), .rst(rst), .i_card_in(i_card_in), .i_acct(i_acct),
    .i_lang(i_lang), .i_passwd(i_passwd), .i_pin_valid(i_pin_valid),
    .i_transactionMenu(i_transactionMenu), .i_txn_valid(i_txn_valid),
    .i_amount(i_amount), .i_dst_acct(i_dst_acct), .i_conf(i_conf),
    .i_cancel(i_cancel), .o_pin(o_pin), .o_depConf(o_depConf),
    .o_withConf(o_withConf), .o_transferConf(o_transferConf),
    .o_balEnq(o_balEnq), .o_balance(o_balance),
    .o_balNotEnough(o_balNotEnough), .o_err(o_err), .o_locked(o_locked),
    .o_busy(o_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int m_bal [4];
  logic [5:0]  obs_res, obs_early;
  logic [15:0] obs_bal;
  logic        obs_pin, obs_err;

  function automatic logic [5:0] pulses();
    return {o_depConf, o_withConf, o_transferConf, o_balEnq, o_balNotEnough, o_err};
  endfunction

  // Reference model: applies the transaction rules to the balance table.
  function automatic logic [5:0] model_txn(int src, logic [2:0] code, int amt, int dst);
    case (code)
      C_DEP: begin
        if (m_bal[src] + amt > BAL_MAX) return R_ERR;
        m_bal[src] += amt;
        return R_DEP;
      end
      C_WITH: begin
        if (amt > m_bal[src]) return R_NEN;
        m_bal[src] -= amt;
        return R_WITH;
      end
      C_XFER: begin
        if (dst == src) return R_ERR;
        if (amt > m_bal[src]) return R_NEN;
        if (m_bal[dst] + amt > BAL_MAX) return R_ERR;
        m_bal[src] -= amt;
        m_bal[dst] += amt;
        return R_XFER;
      end
      C_BAL:   return R_BAL;
      default: return R_ERR;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic insert_card(input logic [1:0] a);
    i_card_in = 1'b1; i_acct = a;
    tick();
  endtask

  task automatic remove_card();
    i_card_in = 1'b0;
    tick(); tick();
  endtask

  task automatic do_lang();
    i_lang = 1'b1; tick(); i_lang = 1'b0;
  endtask

  task automatic do_pin(input logic [3:0] p);
    i_passwd = p; i_pin_valid = 1'b1; tick(); i_pin_valid = 1'b0;
    obs_pin = o_pin;
    obs_err = o_err;
  endtask

  task automatic login(input logic [1:0] a);
    insert_card(a); do_lang(); do_pin(4'hA);
  endtask

  // Drives one menu transaction and records the pulses seen in EXEC and DONE.
  task automatic run_txn(input logic [2:0] code, input logic [15:0] amt, input logic [1:0] dst);
    i_transactionMenu = code; i_txn_valid = 1'b1; tick(); i_txn_valid = 1'b0;
    if (code == C_DEP || code == C_WITH || code == C_XFER) begin
      i_amount = amt; i_dst_acct = dst; i_conf = 1'b1; tick(); i_conf = 1'b0;
    end else if (code != C_BAL) begin
      obs_res   = pulses();
      obs_early = '0;
      return;
    end
    obs_early = pulses();
    tick();
    obs_res = pulses();
    obs_bal = o_balance;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) m_bal[i] = 1000;
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    n_checks++;
    if ({o_pin, o_locked, pulses()} !== 8'h00) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 00000000", {o_pin, o_locked, pulses()});
    end
    n_checks++;
    if (o_balance !== 16'd0) begin n_fail++; $display("FAIL reset_balance: got %0d expected 0", o_balance); end
  endtask

  task automatic test_deposit_overflow();
    login(2'd0);
    n_checks++;
    if (obs_pin !== 1'b1) begin n_fail++; $display("FAIL dep_pin: got %b expected 1", obs_pin); end
    void'(model_txn(0, C_DEP, 65000, 0));
    run_txn(C_DEP, 16'd65000, 2'd0);
    n_checks++;
    if (obs_res !== R_ERR || obs_bal !== 16'd1000) begin
      n_fail++; $display("FAIL dep_overflow: got res %b bal %0d expected %b 1000", obs_res, obs_bal, R_ERR);
    end
    void'(model_txn(0, C_DEP, 64536, 0));
    run_txn(C_DEP, 16'd64536, 2'd0);
    n_checks++;
    if (obs_res !== R_ERR) begin n_fail++; $display("FAIL dep_overflow_edge: got %b expected %b", obs_res, R_ERR); end
    void'(model_txn(0, C_DEP, 0, 0));
    run_txn(C_DEP, 16'd0, 2'd0);
    n_checks++;
    if (obs_res !== R_DEP || obs_bal !== 16'd1000) begin
      n_fail++; $display("FAIL dep_zero: got res %b bal %0d expected %b 1000", obs_res, obs_bal, R_DEP);
    end
    void'(model_txn(0, C_DEP, 250, 0));
    run_txn(C_DEP, 16'd250, 2'd0);
    n_checks++;
    if (obs_early !== 6'd0) begin n_fail++; $display("FAIL dep_latency: pulse at conf+1 got %b expected 000000", obs_early); end
    n_checks++;
    if (obs_res !== R_DEP) begin n_fail++; $display("FAIL dep_250: got %b expected %b", obs_res, R_DEP); end
    run_txn(C_BAL, 16'd0, 2'd0);
    n_checks++;
    if (obs_res !== R_BAL || obs_bal !== 16'd1250) begin
      n_fail++; $display("FAIL dep_enquiry: got res %b bal %0d expected %b 1250", obs_res, obs_bal, R_BAL);
    end
    run_txn(3'b111, 16'd0, 2'd0);
    n_checks++;
    if (obs_res !== R_ERR || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL bad_code: got res %b busy %b expected %b 1", obs_res, o_busy, R_ERR);
    end
    remove_card();
  endtask

  task automatic test_withdraw();
    login(2'd1);
    void'(model_txn(1, C_WITH, 1001, 0));
    run_txn(C_WITH, 16'd1001, 2'd0);
    n_checks++;
    if (obs_res !== R_NEN || obs_bal !== 16'd1000) begin
      n_fail++; $display("FAIL with_overdraw: got res %b bal %0d expected %b 1000", obs_res, obs_bal, R_NEN);
    end
    void'(model_txn(1, C_WITH, 1000, 0));
    run_txn(C_WITH, 16'd1000, 2'd0);
    n_checks++;
    if (obs_res !== R_WITH || obs_bal !== 16'd0) begin
      n_fail++; $display("FAIL with_all: got res %b bal %0d expected %b 0", obs_res, obs_bal, R_WITH);
    end
    void'(model_txn(1, C_WITH, 1, 0));
    run_txn(C_WITH, 16'd1, 2'd0);
    n_checks++;
    if (obs_res !== R_NEN) begin n_fail++; $display("FAIL with_empty: got %b expected %b", obs_res, R_NEN); end
    remove_card();
  endtask

  task automatic test_transfer();
    login(2'd2);
    void'(model_txn(2, C_XFER, 300, 3));
    run_txn(C_XFER, 16'd300, 2'd3);
    n_checks++;
    if (obs_res !== R_XFER || obs_bal !== 16'd700) begin
      n_fail++; $display("FAIL xfer_ok: got res %b bal %0d expected %b 700", obs_res, obs_bal, R_XFER);
    end
    void'(model_txn(2, C_XFER, 100, 2));
    run_txn(C_XFER, 16'd100, 2'd2);
    n_checks++;
    if (obs_res !== R_ERR || obs_bal !== 16'd700) begin
      n_fail++; $display("FAIL xfer_self: got res %b bal %0d expected %b 700", obs_res, obs_bal, R_ERR);
    end
    remove_card();
    login(2'd3);
    run_txn(C_BAL, 16'd0, 2'd0);
    n_checks++;
    if (obs_bal !== 16'd1300) begin n_fail++; $display("FAIL xfer_dst_bal: got %0d expected 1300", obs_bal); end
    remove_card();
  endtask

  task automatic test_abort();
    int cnt;
    logic seen_err;
    login(2'd0);
    i_transactionMenu = C_DEP; i_txn_valid = 1'b1; tick(); i_txn_valid = 1'b0;
    i_cancel = 1'b1; tick(); i_cancel = 1'b0;
    n_checks++;
    if (o_busy !== 1'b0 || pulses() !== 6'd0) begin
      n_fail++; $display("FAIL cancel_amount: got busy %b pulses %b expected 0 000000", o_busy, pulses());
    end
    remove_card();
    login(2'd2);
    i_card_in = 1'b0; tick();
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL card_pull_menu: got busy %b expected 0", o_busy); end
    tick();
    insert_card(2'd3); do_lang();
    cnt = 0; seen_err = 1'b0;
    while (o_busy && cnt < T_CYC + 20) begin
      tick(); cnt++;
      if (o_err) seen_err = 1'b1;
    end
    n_checks++;
    if (o_busy !== 1'b0 || cnt < T_CYC - 1 || cnt > T_CYC + 1) begin
      n_fail++; $display("FAIL timeout_pin: got %0d idle cycles busy %b expected %0d and 0", cnt, o_busy, T_CYC);
    end
    n_checks++;
    if (seen_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b expected 1", seen_err); end
    remove_card();
    login(2'd0);
    run_txn(C_BAL, 16'd0, 2'd0);
    n_checks++;
    if (obs_bal !== 16'(m_bal[0])) begin n_fail++; $display("FAIL abort_bal0: got %0d expected %0d", obs_bal, m_bal[0]); end
    remove_card();
  endtask

  task automatic test_lockout();
    logic [3:0] bad [3];
    bad[0] = 4'h0; bad[1] = 4'h5; bad[2] = 4'hF;
    insert_card(2'd1); do_lang();
    for (int k = 0; k < 2; k++) begin
      do_pin(bad[k]);
      n_checks++;
      if (obs_err !== 1'b0 || o_busy !== 1'b1) begin
        n_fail++; $display("FAIL wrong_pin_%0d: got err %b busy %b expected 0 1", k, obs_err, o_busy);
      end
    end
    do_pin(bad[2]);
    n_checks++;
    if (obs_err !== 1'b1 || o_busy !== 1'b0 || o_locked !== 1'b1) begin
      n_fail++; $display("FAIL lock_third: got err %b busy %b locked %b expected 1 0 1", obs_err, o_busy, o_locked);
    end
    remove_card();
    n_checks++;
    if (o_locked !== 1'b0) begin n_fail++; $display("FAIL lock_release: got %b expected 0", o_locked); end
    insert_card(2'd1);
    n_checks++;
    if (o_err !== 1'b1 || o_locked !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL lock_reinsert: got err %b locked %b busy %b expected 1 1 0", o_err, o_locked, o_busy);
    end
    remove_card();
    login(2'd0);
    n_checks++;
    if (obs_pin !== 1'b1) begin n_fail++; $display("FAIL lock_other_acct: got %b expected 1", obs_pin); end
    remove_card();
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    for (int i = 0; i < 4; i++) m_bal[i] = 1000;
    login(2'd1);
    n_checks++;
    if (obs_pin !== 1'b1 || o_locked !== 1'b0) begin
      n_fail++; $display("FAIL lock_rst_clear: got pin %b locked %b expected 1 0", obs_pin, o_locked);
    end
    run_txn(C_BAL, 16'd0, 2'd0);
    n_checks++;
    if (obs_bal !== 16'd1000) begin n_fail++; $display("FAIL rst_balance: got %0d expected 1000", obs_bal); end
    remove_card();
  endtask

  // Several transactions per session, random accounts, codes and amounts.
  task automatic test_back_to_back();
    for (int s = 0; s < 6; s++) begin
      int src;
      src = int'($urandom_range(0, 3));
      login(2'(src));
      n_checks++;
      if (obs_pin !== 1'b1) begin n_fail++; $display("FAIL rnd_pin s%0d: got %b expected 1", s, obs_pin); end
      for (int t = 0; t < 8; t++) begin
        logic [2:0] code;
        logic [5:0] exp;
        int amt, dst;
        case ($urandom_range(0, 9))
          0, 1, 2: code = C_DEP;
          3, 4:    code = C_WITH;
          5, 6:    code = C_XFER;
          7:       code = C_BAL;
          default: begin
            case ($urandom_range(0, 3))
              0:       code = 3'b000;
              1:       code = 3'b101;
              2:       code = 3'b110;
              default: code = 3'b111;
            endcase
          end
        endcase
        case ($urandom_range(0, 3))
          0:       amt = 0;
          1:       amt = int'($urandom_range(1, 500));
          2:       amt = m_bal[src] + int'($urandom_range(0, 1));
          default: amt = int'($urandom_range(60000, 65535));
        endcase
        if (amt > BAL_MAX) amt = BAL_MAX;
        dst = int'($urandom_range(0, 3));
        exp = model_txn(src, code, amt, dst);
        run_txn(code, 16'(amt), 2'(dst));
        n_checks++;
        if (obs_res !== exp) begin
          n_fail++; $display("FAIL rnd_res s%0d t%0d code %b amt %0d: got %b expected %b", s, t, code, amt, obs_res, exp);
        end
        if (code == C_DEP || code == C_WITH || code == C_XFER || code == C_BAL) begin
          n_checks++;
          if (obs_early !== 6'd0) begin
            n_fail++; $display("FAIL rnd_early s%0d t%0d: got %b expected 000000", s, t, obs_early);
          end
          n_checks++;
          if (obs_bal !== 16'(m_bal[src])) begin
            n_fail++; $display("FAIL rnd_bal s%0d t%0d: got %0d expected %0d", s, t, obs_bal, m_bal[src]);
          end
        end else begin
          n_checks++;
          if (o_busy !== 1'b1) begin n_fail++; $display("FAIL rnd_badcode_stay s%0d t%0d: got busy %b expected 1", s, t, o_busy); end
        end
      end
      remove_card();
    end
  endtask

  initial begin
    rst = 1'b1;
    i_card_in = 1'b0; i_acct = '0; i_lang = 1'b0; i_passwd = '0; i_pin_valid = 1'b0;
    i_transactionMenu = '0; i_txn_valid = 1'b0; i_amount = '0; i_dst_acct = '0;
    i_conf = 1'b0; i_cancel = 1'b0;
    test_reset();
    test_deposit_overflow();
    test_withdraw();
    test_transfer();
    test_abort();
    test_lockout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
